// File: rtl/regfile_access_sequencer.sv
// Register-file access sequencer: accepts an RV32 instruction, reads rs1 and
// rs2 through a single-port register memory, and presents both operands plus
// the rd address. Writebacks always own the memory port and are forwarded
// into operands whose read has already been issued.
module regfile_access_sequencer #(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_WIDTH-1:0] instruction,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic                  wb_valid,
   output logic                  wb_ready,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [WORD_WIDTH-1:0] wb_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   input  logic [WORD_WIDTH-1:0] mem_rdata,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [WORD_WIDTH-1:0] op_rs1_data,
   output logic [WORD_WIDTH-1:0] op_rs2_data,
   output logic [ADDR_WIDTH-1:0] op_rd_addr
);

   typedef enum logic [2:0] {IDLE, READ1, READ2, WAIT, OUT} state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_RS1, TAG_RS2} tag_t;

   state_t                state_q, state_d;
   tag_t                  tag_q, tag_d;
   logic [ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d;
   logic [ADDR_WIDTH-1:0] rs2_addr_q, rs2_addr_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [WORD_WIDTH-1:0] rs1_data_q, rs1_data_d;
   logic [WORD_WIDTH-1:0] rs2_data_q, rs2_data_d;
   logic                  issue_rs1;
   logic                  issue_rs2;
   logic                  wb_write;
   logic                  unused_instr_bits;

   assign wb_ready          = 1'b1;
   assign wb_write          = wb_valid && (wb_addr != '0);
   assign op_rs1_data       = rs1_data_q;
   assign op_rs2_data       = rs2_data_q;
   assign op_rd_addr        = rd_addr_q;
   assign unused_instr_bits = ^{instruction[WORD_WIDTH-1:25], instruction[14:12], instruction[6:0]};

   // State, tag and operand registers; reset discards any in-flight instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tag_q      <= TAG_NONE;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
      end
   end

   // Next-state, handshake outputs and read-issue decisions
   always_comb begin
      state_d     = state_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_addr_d   = rd_addr_q;
      instr_ready = 1'b0;
      op_valid    = 1'b0;
      issue_rs1   = 1'b0;
      issue_rs2   = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = !wb_valid && !rst;
            if (instr_valid && instr_ready) begin
               rs1_addr_d = ADDR_WIDTH'({instruction[19:15], 2'b00});
               rs2_addr_d = ADDR_WIDTH'({instruction[24:20], 2'b00});
               rd_addr_d  = ADDR_WIDTH'({instruction[11:7], 2'b00});
               state_d    = READ1;
            end
         end
         READ1: begin
            if (!wb_valid) begin
               issue_rs1 = 1'b1;
               state_d   = READ2;
            end
         end
         READ2: begin
            if (!wb_valid) begin
               issue_rs2 = 1'b1;
               state_d   = WAIT;
            end
         end
         WAIT: state_d = OUT;
         OUT: begin
            op_valid = 1'b1;
            if (op_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory port: writeback has priority, reads only in free cycles, all quiet in reset
   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst) begin
         if (wb_valid) begin
            mem_we    = wb_write;
            mem_addr  = wb_addr;
            mem_wdata = wb_data;
         end else if (issue_rs1) begin
            mem_re   = 1'b1;
            mem_addr = rs1_addr_q;
         end else if (issue_rs2) begin
            mem_re   = 1'b1;
            mem_addr = rs2_addr_q;
         end
      end
   end

   // Read tag plus operand capture; a forwarded writeback overrides a same-cycle capture
   always_comb begin
      tag_d      = issue_rs1 ? TAG_RS1 : (issue_rs2 ? TAG_RS2 : TAG_NONE);
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      if (tag_q == TAG_RS1) rs1_data_d = (rs1_addr_q == '0) ? '0 : mem_rdata;
      if (tag_q == TAG_RS2) rs2_data_d = (rs2_addr_q == '0) ? '0 : mem_rdata;
      if (wb_write && (wb_addr == rs1_addr_q) && (state_q inside {READ2, WAIT, OUT}))
         rs1_data_d = wb_data;
      if (wb_write && (wb_addr == rs2_addr_q) && (state_q inside {WAIT, OUT}))
         rs2_data_d = wb_data;
   end

endmodule
